// File: rtl/mmm_arbiter_if.sv
// Requester and Montgomery-multiplier signal bundle for mmm_arbiter.
// The slave modport is the arbiter's view; the master modport is the
// environment (requesters plus the multiplier datapath).
interface mmm_arbiter_if #(
  parameter int WIDTH = 8
);
  // Requester side
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] res;
  logic             busy;
  // Multiplier side
  logic             mmm_rst_n;
  logic             mmm_ld_a;
  logic             mmm_ld_r;
  logic [WIDTH-1:0] mmm_a;
  logic [WIDTH-1:0] mmm_b;
  logic [WIDTH-1:0] mmm_p;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, mmm_p,
    output gnt0, gnt1, done0, done1, res, busy,
           mmm_rst_n, mmm_ld_a, mmm_ld_r, mmm_a, mmm_b
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, mmm_p,
    input  gnt0, gnt1, done0, done1, res, busy,
           mmm_rst_n, mmm_ld_a, mmm_ld_r, mmm_a, mmm_b
  );
endinterface

// File: rtl/mmm_arbiter.sv
// Round-robin arbiter and control sequencer for one shared Montgomery
// multiplier. Two requesters, one operation in flight at a time.
//
// Handshake: a requester raises reqN and holds its operands until gntN; the
// operands are captured in the IDLE cycle that grants it. reqN is only looked
// at in IDLE, so it may drop at any time after the grant. doneN is a one-cycle
// pulse during which res holds the product; the requester must drop reqN in
// that same cycle, otherwise the following IDLE cycle sees a fresh request.
module mmm_arbiter #(
  parameter int WIDTH = 8,
  parameter int LAT   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  mmm_arbiter_if.slave       bus,
  output logic [2:0]         o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // RUN ends in the cycle where the counter reaches LAT-1.
  localparam logic [7:0] CNT_LAST = 8'(LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_cnt;
  logic             r_last;
  logic             r_sel;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;

  logic             w_any_req;
  logic             w_win;

  // Winner: a lone requester wins; on a tie the port not served last wins.
  assign w_any_req = bus.req0 | bus.req1;
  assign w_win     = (bus.req0 & bus.req1) ? ~r_last : bus.req1;

  // State register; en low freezes the sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (en) begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_any_req) w_next = S_LOAD;
      S_LOAD:    w_next = S_RUN;
      S_RUN:     if (r_cnt == CNT_LAST) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Datapath: arbitration memory, operand latch, latency counter, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 8'd0;
      r_last <= 1'b1;
      r_sel  <= 1'b0;
      r_opa  <= '0;
      r_opb  <= '0;
      r_res  <= '0;
    end else if (en) begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel  <= w_win;
            r_last <= w_win;
            r_opa  <= w_win ? bus.a1 : bus.a0;
            r_opb  <= w_win ? bus.b1 : bus.b0;
          end
        end
        S_LOAD:    r_cnt <= 8'd0;
        S_RUN:     r_cnt <= r_cnt + 8'd1;
        S_CAPTURE: r_res <= bus.mmm_p;
        default:   ;
      endcase
    end
  end

  // Moore output decode from the registered state and served port.
  always_comb begin
    bus.gnt0      = 1'b0;
    bus.gnt1      = 1'b0;
    bus.done0     = 1'b0;
    bus.done1     = 1'b0;
    bus.mmm_rst_n = 1'b0;
    bus.mmm_ld_a  = 1'b0;
    bus.mmm_ld_r  = 1'b0;
    case (r_state)
      S_LOAD: begin
        bus.mmm_rst_n = 1'b1;
        bus.mmm_ld_a  = 1'b1;
        bus.gnt0      = ~r_sel;
        bus.gnt1      = r_sel;
      end
      S_RUN: begin
        bus.mmm_rst_n = 1'b1;
        bus.gnt0      = ~r_sel;
        bus.gnt1      = r_sel;
      end
      S_CAPTURE: begin
        bus.mmm_rst_n = 1'b1;
        bus.mmm_ld_r  = 1'b1;
        bus.gnt0      = ~r_sel;
        bus.gnt1      = r_sel;
      end
      S_DONE: begin
        bus.mmm_rst_n = 1'b1;
        bus.gnt0      = ~r_sel;
        bus.gnt1      = r_sel;
        bus.done0     = ~r_sel;
        bus.done1     = r_sel;
      end
      default: ;
    endcase
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.res     = r_res;
  assign bus.mmm_a   = r_opa;
  assign bus.mmm_b   = r_opb;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mmm_arbiter.sv
// Directed bench for mmm_arbiter (WIDTH=8, LAT=10). The multiplier stand-in
// produces (a + b + 9) mod 256, valid LAT enabled cycles after mmm_ld_a.
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_mmm_arbiter;

  localparam int WIDTH = 8;
  localparam int LAT   = 10;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  always #5 clk = ~clk;

  mmm_arbiter_if #(.WIDTH(WIDTH)) bus ();
  logic [2:0] dbg_state;

  mmm_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- multiplier stand-in ----------------
  int         m_cnt  = 0;
  logic [7:0] m_prod = 8'h00;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0;
    end else if (en) begin
      if (!bus.mmm_rst_n) begin
        m_cnt <= 0;
      end else if (bus.mmm_ld_a) begin
        m_cnt  <= 1;
        m_prod <= bus.mmm_a + bus.mmm_b + 8'h09;
      end else if (m_cnt != 0 && m_cnt < 255) begin
        m_cnt <= m_cnt + 1;
      end
    end
  end
  assign bus.mmm_p = (m_cnt >= LAT) ? m_prod : 8'hEE;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];   // {port, result}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- event recorder ----------------
  int         cyc;
  int         ev_lda, ev_ldr, ev_gnt, ev_done, ev_port;
  logic [7:0] ev_res, ev_mmm_a;
  bit         seen_g0, seen_g1, seen_d0, seen_d1;

  task automatic clr_ev();
    cyc = 0; ev_lda = -1; ev_ldr = -1; ev_gnt = -1; ev_done = -1; ev_port = -1;
    ev_res = 8'h00; ev_mmm_a = 8'h00;
    seen_g0 = 0; seen_g1 = 0; seen_d0 = 0; seen_d1 = 0;
  endtask

  // Advance one cycle and log what the DUT is showing in the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.gnt0) seen_g0 = 1;
    if (bus.gnt1) seen_g1 = 1;
    if (bus.done0) seen_d0 = 1;
    if (bus.done1) seen_d1 = 1;
    if (bus.mmm_ld_a && ev_lda < 0) ev_lda = cyc;
    if (bus.mmm_ld_r && ev_ldr < 0) ev_ldr = cyc;
    if ((bus.gnt0 || bus.gnt1) && ev_gnt < 0) ev_gnt = cyc;
    if ((bus.done0 || bus.done1) && ev_done < 0) begin
      ev_done  = cyc;
      ev_port  = bus.done1 ? 1 : 0;
      ev_res   = bus.res;
      ev_mmm_a = bus.mmm_a;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_req0(input logic [7:0] a, input logic [7:0] b);
    bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
    clr_ev();
  endtask

  task automatic drive_req1(input logic [7:0] a, input logic [7:0] b);
    bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1;
    clr_ev();
  endtask

  int         n_done;
  int         last_done;
  logic [8:0] exp_e;

  initial begin
    // ---- reset with random requests ----
    bus.req0 = 1'($urandom_range(0, 1));
    bus.req1 = 1'($urandom_range(0, 1));
    bus.a0 = 8'($urandom_range(0, 255)); bus.b0 = 8'($urandom_range(0, 255));
    bus.a1 = 8'($urandom_range(0, 255)); bus.b1 = 8'($urandom_range(0, 255));
    clr_ev();
    step();
    step();
    check("rst_state",  32'(dbg_state), 32'(ST_IDLE));
    check("rst_gnt",    {bus.gnt1, bus.gnt0}, 0);
    check("rst_done",   {bus.done1, bus.done0}, 0);
    check("rst_busy",   32'(bus.busy), 0);
    check("rst_ld",     {bus.mmm_ld_r, bus.mmm_ld_a}, 0);
    check("rst_mmm_rn", 32'(bus.mmm_rst_n), 0);
    check("rst_res",    32'(bus.res), 0);
    check("rst_ops",    {bus.mmm_a, bus.mmm_b}, 0);

    // ---- simultaneous requests, held high: 0,1,0,1 ----
    rst = 1'b0;
    bus.a0 = 8'h11; bus.b0 = 8'h22;   // 0x11+0x22+9 = 0x3C
    bus.a1 = 8'h40; bus.b1 = 8'h05;   // 0x40+0x05+9 = 0x4E
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    clr_ev();
    exp_q.push_back({1'b0, 8'h3C});
    exp_q.push_back({1'b1, 8'h4E});
    exp_q.push_back({1'b0, 8'h3C});
    exp_q.push_back({1'b1, 8'h4E});
    n_done = 0;
    last_done = -1;
    for (int c = 0; c < 80 && n_done < 4; c++) begin
      step();
      if (bus.done0 || bus.done1) begin
        exp_e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
        check("tie_port", 32'(bus.done1), 32'(exp_e[8]));
        check("tie_res",  32'(bus.res),   32'(exp_e[7:0]));
        if (n_done == 0) check("tie_first_done", cyc, 13);
        else             check("tie_gap", cyc - last_done, 14);
        last_done = cyc;
        n_done++;
        if (n_done == 4) begin
          bus.req0 = 1'b0; bus.req1 = 1'b0;
        end
      end
    end
    check("tie_count", n_done, 4);

    // ---- single request on port 0 ----
    step();                             // IDLE with no request
    drive_req0(8'h35, 8'h1C);           // expect 0x5A
    for (int c = 0; c < 40 && ev_done < 0; c++) begin
      step();
      if (bus.done0) bus.req0 = 1'b0;
    end
    check("single_lda",  ev_lda, 1);
    check("single_gnt",  ev_gnt, 1);
    check("single_ldr",  ev_ldr, 12);
    check("single_done", ev_done, 13);
    check("single_port", ev_port, 0);
    check("single_res",  32'(ev_res), 32'h5A);
    check("single_g1",   32'(seen_g1), 0);
    check("single_d1",   32'(seen_d1), 0);

    // ---- operand change and request drop mid-operation ----
    step();
    drive_req0(8'h10, 8'h20);           // expect 0x39
    for (int c = 0; c < 40 && ev_done < 0; c++) begin
      step();
      if (cyc == 3) bus.a0 = 8'hFF;
      if (cyc == 5) bus.req0 = 1'b0;
    end
    check("chg_done",  ev_done, 13);
    check("chg_port",  ev_port, 0);
    check("chg_res",   32'(ev_res), 32'h39);
    check("chg_mmm_a", 32'(ev_mmm_a), 32'h10);

    // ---- enable stall during RUN ----
    step();
    drive_req0(8'h02, 8'h03);           // expect 0x0E
    for (int c = 0; c < 40 && ev_done < 0; c++) begin
      step();
      if (cyc >= 5 && cyc <= 8) begin
        check("stall_state", 32'(dbg_state), 32'(ST_RUN));
        check("stall_outs",  {bus.busy, bus.gnt0, bus.mmm_rst_n, bus.mmm_ld_a, bus.mmm_ld_r},
                             5'b11100);
        check("stall_mmm_a", 32'(bus.mmm_a), 32'h02);
      end
      if (cyc == 4) en = 1'b0;
      if (cyc == 8) en = 1'b1;
      if (bus.done0) bus.req0 = 1'b0;
    end
    check("stall_done", ev_done, 17);
    check("stall_res",  32'(ev_res), 32'h0E);

    // ---- reset mid-operation, then a port-1 request ----
    step();
    drive_req0(8'h44, 8'h55);
    for (int c = 0; c < 7; c++) begin
      step();
      if (cyc == 6) rst = 1'b1;
      if (cyc == 7) begin
        rst = 1'b0;
        bus.req0 = 1'b0;
      end
    end
    check("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mrst_busy",  32'(bus.busy), 0);
    check("mrst_res",   32'(bus.res), 0);
    check("mrst_nodone", 32'(seen_d0 | seen_d1), 0);

    drive_req1(8'h07, 8'h08);           // expect 0x18
    for (int c = 0; c < 40 && ev_done < 0; c++) begin
      step();
      if (bus.done1) bus.req1 = 1'b0;
    end
    check("p1_done", ev_done, 13);
    check("p1_port", ev_port, 1);
    check("p1_res",  32'(ev_res), 32'h18);
    check("p1_g0",   32'(seen_g0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmm_arbiter.md
# mmm_arbiter

Shares one Montgomery modular multiplier (MMM) between two requesters: the exponentiation sequencer (port 0) and the host/key-setup path (port 1). It arbitrates round-robin, latches the winner's operands, and sequences the multiplier's clear/load-operand/load-result controls over a fixed computation latency. It then returns the product to the winner with a one-cycle done pulse. The block sits between the requesters and the MMM datapath and is its only driver.

## Interface
- `WIDTH`, 8: operand/result width in bits.
- `LAT`, 10: MMM computation cycles from operand load to valid product; legal range 1..255.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high; overrides `en`.
- `en`  in  1  clock enable; low freezes all state.
- `req0`, `req1`  in  1  request; held high until the matching done.
- `a0`, `b0`, `a1`, `b1`  in  WIDTH  operands, sampled only when the request is granted.
- `gnt0`, `gnt1`  out  1  high from LOAD through DONE for the served port.
- `done0`, `done1`  out  1  one-cycle pulse: `res` is valid for the served port.
- `res`  out  WIDTH  last captured product; held until the next capture.
- `busy`  out  1  state != IDLE.
- `mmm_rst_n`  out  1  MMM clear, active-low.
- `mmm_ld_a`  out  1  MMM operand-load strobe.
- `mmm_ld_r`  out  1  MMM result-register load strobe.
- `mmm_a`, `mmm_b`  out  WIDTH  latched operands to the MMM.
- `mmm_p`  in  WIDTH  MMM product; valid `LAT` cycles after `mmm_ld_a`.

## Operation
- **States:** IDLE, LOAD, RUN, CAPTURE, DONE.
- **Outputs:** all outputs are Moore, decoded from registered state. There is no combinational path from `req*` to any output.
- **IDLE**
  - Drives `mmm_rst_n`=0, which holds the MMM cleared.
  - If any request is high: pick the winner, latch its `a`/`b` into the operand registers, set `sel`=winner, go to LOAD.
- **Arbitration**
  - Single request: that port wins.
  - Both requests: the port not equal to `last` wins.
  - `last` updates to the winner on entry to LOAD.
- **LOAD**
  - Drives `mmm_rst_n`=1, `mmm_ld_a`=1, `gnt[sel]`=1.
  - Clears the cycle counter; goes to RUN.
- **RUN**
  - Drives `mmm_rst_n`=1.
  - Counter increments each enabled cycle; when counter == `LAT`-1, go to CAPTURE.
- **CAPTURE**
  - Drives `mmm_ld_r`=1.
  - Loads `res` <= `mmm_p` at the end of the cycle; goes to DONE.
- **DONE**
  - Drives `done[sel]`=1 and keeps `gnt[sel]`=1; goes to IDLE.
- **Operands:** `mmm_a`/`mmm_b` stay at the latched values from LOAD through DONE. Requester operand changes after the grant have no effect.
- **Request deassertion:** `req` is sampled only in IDLE. Dropping `req` mid-operation is ignored; the operation completes and `done` still pulses.
- **Request handshake:** the requester must drop `req` in the cycle it sees `done`. If `req` is still high in the next IDLE cycle, it is a new request.
- **Enable:**
  - `en`=0 holds the state, counter, `last`, operand registers, `res` and every output at their current values.
  - The MMM shares the same `en`, so the latency count stays aligned.
- **Reset values:**
  - State IDLE; counter 0; `last`=1, so port 0 wins the first tie.
  - Operand registers and `res` = 0.
  - `gnt*`=0, `done*`=0, `busy`=0, `mmm_ld_a`=0, `mmm_ld_r`=0, `mmm_rst_n`=0, `mmm_a`=`mmm_b`=0.
- **Mid-operation reset:** aborts the operation. No `done` pulse, and `res` returns to 0.

## Timing
Cycle 0 is the IDLE cycle in which a request is sampled high (`en`=1 throughout):

- Cycle 1: LOAD. `gnt` and `mmm_ld_a` go high, and `mmm_a`/`mmm_b` are valid.
- Cycles 2 .. `LAT`+1: RUN.
- Cycle `LAT`+2: CAPTURE, with `mmm_ld_r`=1.
- Cycle `LAT`+3: DONE. `done` is high and `res` is valid.
- Cycle `LAT`+4: IDLE. This is the earliest cycle a new request can be sampled.

Derived figures:
- Request-to-done latency is `LAT`+3 cycles.
- Back-to-back throughput is one product per `LAT`+4 cycles.
- Every cycle with `en`=0 stretches the affected phase by one cycle.
- `LAT`=1 gives RUN exactly one cycle.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `en`=1 and random `req`.
  - Every output must be at its reset value, including `mmm_rst_n`=0 and `res`=0.
  - After release, the first arbitration tie must grant port 0.
- **Single request:** `LAT`=10; `req0` with `a0`=0x35, `b0`=0x1C, MMM model returning 0x5A.
  - `mmm_ld_a` must pulse in cycle 1 and `mmm_ld_r` in cycle 12.
  - `done0` must pulse in cycle 13 with `res`=0x5A.
  - `gnt1` and `done1` must stay 0.
- **Simultaneous requests:** `req0` and `req1` held high continuously.
  - Grants must alternate 0,1,0,1 with done pulses 14 cycles apart.
  - Each `res` must match its own port's operands.
- **Operand and request changes mid-operation:** change `a0` in cycle 3 and drop `req0` in cycle 5.
  - The operation must complete with the originally latched operands.
  - `done0` must still pulse in cycle 13.
- **Enable stall:** drop `en` for 4 cycles during RUN.
  - All outputs must hold.
  - `done0` must move from cycle 13 to cycle 17 with the correct `res`.
- **Reset mid-operation:** assert `rst` in cycle 6.
  - State must return to IDLE with no `done` pulse and `res`=0.
  - A subsequent `req1` must complete normally.
